// File: rtl/cv32e40p_apu_arbiter_if.sv
// Bundle of the two-requester APU port and the shared FPU port seen by the arbiter.
// Handshakes: a requester/FPU transfer happens on any cycle where req and gnt are both high;
// results need no ready, rvalid is a one-cycle strobe and the data is valid only while it is high.
interface cv32e40p_apu_arbiter_if #(
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
);
  logic [1:0]                               req_i;
  logic [1:0]                               gnt_o;
  logic [1:0][APU_NARGS-1:0][31:0]          operands_i;
  logic [1:0][APU_WOP-1:0]                  op_i;
  logic [1:0][APU_NDSFLAGS-1:0]             flags_i;
  logic [1:0]                               rvalid_o;
  logic [31:0]                              rdata_o;
  logic [APU_NUSFLAGS-1:0]                  rflags_o;
  logic                                     fpu_req_o;
  logic                                     fpu_gnt_i;
  logic [APU_NARGS-1:0][31:0]               fpu_operands_o;
  logic [APU_WOP-1:0]                       fpu_op_o;
  logic [APU_NDSFLAGS-1:0]                  fpu_flags_o;
  logic                                     fpu_rvalid_i;
  logic [31:0]                              fpu_rdata_i;
  logic [APU_NUSFLAGS-1:0]                  fpu_rflags_i;
  logic                                     busy_o;
  logic                                     spurious_o;

  modport slave (
    input  req_i, operands_i, op_i, flags_i,
    input  fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
    output gnt_o, rvalid_o, rdata_o, rflags_o,
    output fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o,
    output busy_o, spurious_o
  );

  modport master (
    output req_i, operands_i, op_i, flags_i,
    output fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
    input  gnt_o, rvalid_o, rdata_o, rflags_o,
    input  fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o,
    input  busy_o, spurious_o
  );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one in-order FPU between two cores; a tag FIFO of
// requester ids routes each response back to the core that issued it.
module cv32e40p_apu_arbiter #(
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5,
  parameter int TAG_DEPTH    = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  cv32e40p_apu_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] occ_q;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic             tag_q [TAG_DEPTH];
  logic             rr_q;        // requester favoured when both ask
  logic             spurious_q;

  logic sel;
  logic tag_full;
  logic push;
  logic pop;

  always_comb begin
    sel = rr_q;
    unique case (bus.req_i)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = rr_q;
    endcase

    // Registered occupancy only: a same-cycle pop never frees a slot for a push.
    tag_full = (occ_q == CNT_W'(TAG_DEPTH));
    push     = 1'b0;
    pop      = 1'b0;

    bus.fpu_req_o = !rst_i && (|bus.req_i) && !tag_full;
    push          = bus.fpu_req_o && bus.fpu_gnt_i;
    bus.gnt_o     = 2'b00;
    if (push) bus.gnt_o[sel] = 1'b1;

    pop          = !rst_i && bus.fpu_rvalid_i && (occ_q != '0);
    bus.rvalid_o = 2'b00;
    if (pop) bus.rvalid_o[tag_q[rptr_q]] = 1'b1;

    bus.fpu_operands_o = bus.operands_i[sel];
    bus.fpu_op_o       = bus.op_i[sel];
    bus.fpu_flags_o    = bus.flags_i[sel];
    bus.rdata_o        = bus.fpu_rdata_i;
    bus.rflags_o       = bus.fpu_rflags_i;
    bus.busy_o         = (occ_q != '0);
    bus.spurious_o     = spurious_q;
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_q[wptr_q] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rr_q       <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        rr_q   <= ~sel;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (bus.fpu_rvalid_i && (occ_q == '0)) spurious_q <= 1'b1;
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed scenarios plus randomized traffic for cv32e40p_apu_arbiter, checked
// every cycle against an owner-queue model of the arbiter.
module tb_cv32e40p_apu_arbiter;
  localparam int NARGS = 3;
  localparam int WOP   = 6;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv32e40p_apu_arbiter_if #(
    .APU_NARGS(NARGS), .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)
  ) bus ();

  cv32e40p_apu_arbiter #(
    .APU_NARGS(NARGS), .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS),
    .TAG_DEPTH(DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q holds the owner of each outstanding FPU operation, oldest first.
  logic [0:0] exp_q[$];
  int         last_granted;
  bit         spur_m;
  bit         model_valid = 1'b0;
  int         m_sel;
  int         m_size;
  logic       m_req;
  logic [1:0] m_gnt;
  logic [1:0] m_rv;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", bus.gnt_o, 2'b00);
      chk("rst_fpu_req", bus.fpu_req_o, 1'b0);
      chk("rst_rvalid", bus.rvalid_o, 2'b00);
      exp_q.delete();
      last_granted = 1;
      spur_m       = 1'b0;
      model_valid  = 1'b1;
    end else if (model_valid) begin
      m_size = exp_q.size();
      chk("busy", bus.busy_o, m_size != 0);
      chk("spurious", bus.spurious_o, spur_m);
      if (bus.req_i == 2'b11) m_sel = 1 - last_granted;
      else                    m_sel = bus.req_i[1] ? 1 : 0;
      m_req = (bus.req_i != 2'b00) && (m_size < DEPTH);
      m_gnt = (m_req && bus.fpu_gnt_i) ? (2'b01 << m_sel) : 2'b00;
      m_rv  = (bus.fpu_rvalid_i && m_size > 0) ? (2'b01 << exp_q[0]) : 2'b00;
      chk("fpu_req", bus.fpu_req_o, m_req);
      chk("gnt", bus.gnt_o, m_gnt);
      chk("rvalid", bus.rvalid_o, m_rv);
      if (m_req) begin
        chk("fpu_operands", bus.fpu_operands_o, bus.operands_i[m_sel]);
        chk("fpu_op", bus.fpu_op_o, bus.op_i[m_sel]);
        chk("fpu_flags", bus.fpu_flags_o, bus.flags_i[m_sel]);
      end
      if (m_rv != 2'b00) begin
        chk("rdata", bus.rdata_o, bus.fpu_rdata_i);
        chk("rflags", bus.rflags_o, bus.fpu_rflags_i);
      end
      if (m_rv != 2'b00) void'(exp_q.pop_front());
      if (bus.fpu_rvalid_i && m_size == 0) spur_m = 1'b1;
      if (m_gnt != 2'b00) begin
        exp_q.push_back(m_sel[0]);
        last_granted = m_sel;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NARGS; k++) bus.operands_i[r][k] = $urandom;
      bus.op_i[r]    = WOP'($urandom);
      bus.flags_i[r] = NDS'($urandom);
    end
    bus.fpu_rdata_i  = $urandom;
    bus.fpu_rflags_i = NUS'($urandom);
  endtask

  task automatic idle();
    bus.req_i        = 2'b00;
    bus.fpu_gnt_i    = 1'b0;
    bus.fpu_rvalid_i = 1'b0;
    rand_payload();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  logic [1:0] rr_seq [4];

  // ---------------- directed + random stimulus ----------------
  initial begin
    rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    idle();
    next_cycle();
    do_reset();
    @(negedge clk);
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_spurious", bus.spurious_o, 1'b0);
    chk("reset_gnt", bus.gnt_o, 2'b00);

    // single requester round trip
    do_reset();
    bus.req_i = 2'b01; bus.fpu_gnt_i = 1'b1;
    @(negedge clk); chk("single_gnt", bus.gnt_o, 2'b01);
    next_cycle(); idle();
    @(negedge clk); chk("single_busy", bus.busy_o, 1'b1); chk("single_gnt_once", bus.gnt_o, 2'b00);
    next_cycle(); next_cycle();
    bus.fpu_rvalid_i = 1'b1; bus.fpu_rdata_i = 32'h3F80_0000;
    @(negedge clk); chk("single_rvalid", bus.rvalid_o, 2'b01); chk("single_rdata", bus.rdata_o, 32'h3F80_0000);
    next_cycle(); idle();
    @(negedge clk); chk("single_busy_end", bus.busy_o, 1'b0);

    // contention alternates and responses follow issue order
    do_reset();
    bus.req_i = 2'b11; bus.fpu_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("rr_gnt%0d", i), bus.gnt_o, rr_seq[i]);
      next_cycle(); rand_payload();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.fpu_rvalid_i = 1'b1;
      @(negedge clk); chk($sformatf("rr_rvalid%0d", i), bus.rvalid_o, rr_seq[i]);
      next_cycle();
    end
    idle();

    // tag FIFO full blocks requests; a pop does not free the slot that same cycle
    do_reset();
    bus.req_i = 2'b01; bus.fpu_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("fill_gnt%0d", i), bus.gnt_o, 2'b01);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("full_fpu_req", bus.fpu_req_o, 1'b0); chk("full_gnt", bus.gnt_o, 2'b00);
      next_cycle();
    end
    bus.fpu_rvalid_i = 1'b1;
    @(negedge clk);
    chk("full_pop_fpu_req", bus.fpu_req_o, 1'b0);
    chk("full_pop_gnt", bus.gnt_o, 2'b00);
    chk("full_pop_rvalid", bus.rvalid_o, 2'b01);
    next_cycle(); bus.fpu_rvalid_i = 1'b0;
    @(negedge clk); chk("after_pop_fpu_req", bus.fpu_req_o, 1'b1); chk("after_pop_gnt", bus.gnt_o, 2'b01);
    next_cycle(); idle();
    for (int i = 0; i < 4; i++) begin
      bus.fpu_rvalid_i = 1'b1;
      @(negedge clk); chk($sformatf("drain_rvalid%0d", i), bus.rvalid_o, 2'b01);
      next_cycle();
    end
    idle();
    @(negedge clk); chk("drain_busy", bus.busy_o, 1'b0);

    // spurious response with nothing outstanding
    do_reset();
    bus.fpu_rvalid_i = 1'b1;
    @(negedge clk); chk("spur_rvalid", bus.rvalid_o, 2'b00);
    next_cycle(); idle();
    @(negedge clk); chk("spur_flag", bus.spurious_o, 1'b1); chk("spur_busy", bus.busy_o, 1'b0);
    next_cycle(); next_cycle();
    @(negedge clk); chk("spur_sticky", bus.spurious_o, 1'b1);

    // reset with two operations in flight
    do_reset();
    bus.req_i = 2'b01; bus.fpu_gnt_i = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b1;
    @(negedge clk); chk("midrst_gnt", bus.gnt_o, 2'b00); chk("midrst_fpu_req", bus.fpu_req_o, 1'b0);
    next_cycle(); rst = 1'b0; idle();
    @(negedge clk); chk("midrst_busy", bus.busy_o, 1'b0); chk("midrst_spur_clr", bus.spurious_o, 1'b0);
    next_cycle(); bus.fpu_rvalid_i = 1'b1;
    @(negedge clk); chk("midrst_rvalid", bus.rvalid_o, 2'b00);
    next_cycle(); idle();
    @(negedge clk); chk("midrst_spur", bus.spurious_o, 1'b1);

    // stall keeps priority unchanged
    do_reset();
    bus.req_i = 2'b10; bus.fpu_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("stall_gnt", bus.gnt_o, 2'b00); chk("stall_fpu_req", bus.fpu_req_o, 1'b1);
      next_cycle();
    end
    bus.fpu_gnt_i = 1'b1;
    @(negedge clk); chk("stall_release", bus.gnt_o, 2'b10);
    next_cycle(); bus.req_i = 2'b11; bus.fpu_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("stall2_gnt", bus.gnt_o, 2'b00);
      next_cycle();
    end
    bus.fpu_gnt_i = 1'b1;
    @(negedge clk); chk("stall2_first", bus.gnt_o, 2'b01);
    next_cycle();
    @(negedge clk); chk("stall2_second", bus.gnt_o, 2'b10);
    next_cycle(); idle();

    // randomized traffic checked by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.req_i        = 2'($urandom_range(0, 3));
      bus.fpu_gnt_i    = ($urandom_range(0, 3) != 0);
      bus.fpu_rvalid_i = ($urandom_range(0, 2) == 0);
      rand_payload();
      next_cycle();
    end
    rst = 1'b0;
    idle();
    next_cycle(); next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
